fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage: PC generation, in-order pipelined requests to a variable-latency
//  instruction memory, and a DEPTH-entry fetch queue feeding decode over valid/ready. Replaces the
//  single-register IF/ID latch. Adds branch redirect with flush of in-flight fetches and backpressure.
// PARAMETERS
//  XLEN       32   address / PC width
//  ILEN       32   instruction width
//  INST_BYTES 4    PC increment per sequential fetch
//  RESET_VEC  0    PC value after reset (XLEN bits)
//  DEPTH      4    fetch-queue entries; power of two, >= 2; also the max outstanding requests
// PORTS
//  clk             in   1     clock, all state on rising edge
//  reset           in   1     asynchronous, active-high reset
//  fetch_en        in   1     0 = issue no new requests (queue still drains/fills)
//  redirect_valid  in   1     branch/jump taken: restart fetch at redirect_pc
//  redirect_pc     in   XLEN  redirect target
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     imem accepts request this cycle
//  imem_req_addr   out  XLEN  fetch address (= current PC)
//  imem_rsp_valid  in   1     response data valid; responses return in request order, latency >= 1
//  imem_rsp_data   in   ILEN  fetched instruction
//  id_valid        out  1     head entry holds a complete instruction
//  id_ready        in   1     decode consumes head this cycle (0 = stall)
//  id_pc           out  XLEN  PC of head instruction
//  id_inst         out  ILEN  head instruction
// BEHAVIOUR
//  Reset (async): pc=RESET_VEC, queue empty (count=0, head=tail=fill ptr=0), drop_cnt=0; outputs:
//   imem_req_valid=0 (gated by reset), id_valid=0, id_pc=0, id_inst=0 while reset asserted.
//  Queue entry = {pc, inst, filled}. Slot allocated at request handshake (pc written, filled=0);
//   inst written and filled=1 at the next in-order response. Outstanding = allocated - filled.
//  imem_req_valid = !reset & fetch_en & !redirect_valid & (count < DEPTH); imem_req_addr = pc.
//  Handshake (req_valid & req_ready): allocate at tail, pc <= pc + INST_BYTES (wraps mod 2^XLEN).
//   req_valid may drop without a handshake; addr is stable only while valid and not redirected.
//  Response: if drop_cnt != 0 -> discard, drop_cnt--; else fill oldest unfilled entry.
//   Response with zero outstanding and drop_cnt==0 is a protocol error: ignored (assertion in bench).
//  id_valid = head.filled; id_pc/id_inst = head fields; pop on id_valid & id_ready.
//  Full: count==DEPTH blocks requests; count is registered, so a pop does not free a slot for a
//   request in the same cycle (one-cycle bubble, by design). Empty: id_valid=0, id_pc/id_inst hold last.
//  Same-cycle alloc + pop + fill all permitted when count < DEPTH.
//  Redirect (highest priority): pc <= redirect_pc; queue cleared (count=0, ptrs=0, filled=0);
//   no request issued this cycle; no pop regardless of id_ready;
//   drop_cnt <= drop_cnt + outstanding - (imem_rsp_valid ? 1 : 0) (the same-cycle response is discarded).
//   First request to redirect_pc may issue the following cycle.
//  Latency: request accepted at cycle N, response at N+L -> id_valid at N+L+1 (queue registered).
//  Sustained throughput 1 instr/cycle when L+1 < DEPTH and id_ready=1.
//  Counters: count, drop_cnt are $clog2(DEPTH+1) bits; pointers $clog2(DEPTH) bits, natural wrap.
//  Reset mid-operation: all state cleared; imem is reset by the same signal, so no stale responses.
// STRUCTURE
//  Shared package rv_pkg: XLEN, ILEN, INST_BYTES, RESET_VEC constants; typedef fetch_entry_t
//   {pc, inst, filled}.
//  Sub-module fetch_queue: DEPTH-entry circular buffer with alloc(tail), fill(fill ptr), pop(head),
//   clear; exports count, outstanding, head entry. fetch_unit holds pc, drop_cnt, handshake logic.
// TESTING
//  1 Reset then fetch_en=1, req_ready=1, fixed latency 1, id_ready=1 -> addrs 0,4,8,...;
//    id_pc/id_inst in order, one per cycle after fill, no gaps.
//  2 id_ready=0 for 10 cycles -> exactly DEPTH (4) requests issued, req_valid=0 after; release ->
//    entries pop in order, no loss or duplication.
//  3 Latency 3, two requests outstanding, redirect to 0x100 -> both late responses dropped
//    (drop_cnt 2->0), next id_pc=0x100 with its instruction.
//  4 Redirect in the same cycle as a response and id_ready=1 -> response discarded, no pop,
//    no request that cycle; next request addr = redirect_pc.
//  5 imem_req_ready toggling randomly, random latency 1-5 -> output stream equals the sequential
//    program image; pc wrap from 0xFFFF_FFFC -> 0x0.
//  6 Assert reset mid-stream with queue full -> id_valid, imem_req_valid drop immediately (async);
//    after release fetch restarts at RESET_VEC.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared fetch-stage constants and the fetch-queue entry type.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] INST_BYTES = 32'd4;
    localparam logic [XLEN-1:0] RESET_VEC  = 32'h0000_0000;

    // One fetch-queue slot: the PC is known at request time, the
    // instruction arrives later and sets 'filled'.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry circular fetch queue.
// - A slot is allocated at the tail when a request is accepted.
// - Slots are filled in order through a separate fill pointer as responses arrive.
// - Slots are popped at the head.
// Clear empties the queue in one cycle; it is used on a redirect.
module fetch_queue
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear_i,
    input  logic                         alloc_i,
    input  logic [XLEN-1:0]              alloc_pc_i,
    input  logic                         fill_i,
    input  logic [ILEN-1:0]              fill_inst_i,
    input  logic                         pop_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [$clog2(DEPTH+1)-1:0]   outst_o,
    output fetch_entry_t                 head_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [PW-1:0] fptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] outst_q;
    logic          fill_ok_s;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign fill_ok_s = fill_i & (outst_q != {CW{1'b0}});

    // Queue storage, pointers and occupancy counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            fptr_q  <= '0;
            count_q <= '0;
            outst_q <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i].filled <= 1'b0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            fptr_q  <= '0;
            count_q <= '0;
            outst_q <= '0;
        end else begin
            // Alloc, fill and pop always touch distinct slots while count < DEPTH.
            if (alloc_i) begin
                mem_q[tail_q].pc     <= alloc_pc_i;
                mem_q[tail_q].filled <= 1'b0;
                tail_q               <= tail_q + PW'(1);
            end
            if (fill_ok_s) begin
                mem_q[fptr_q].inst   <= fill_inst_i;
                mem_q[fptr_q].filled <= 1'b1;
                fptr_q               <= fptr_q + PW'(1);
            end
            // Clearing 'filled' on pop keeps a later empty head from looking valid.
            if (pop_i) begin
                mem_q[head_q].filled <= 1'b0;
                head_q               <= head_q + PW'(1);
            end
            count_q <= count_q + CW'(alloc_i) - CW'(pop_i);
            outst_q <= outst_q + CW'(alloc_i) - CW'(fill_ok_s);
        end
    end

    assign count_o = count_q;
    assign outst_o = outst_q;
    assign head_o  = mem_q[head_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. It generates the PC and issues in-order pipelined
// instruction-memory requests. A fetch queue feeds decode over valid/ready.
// On a redirect the queue is flushed. Responses still in flight for the old
// path are counted in drop_cnt and discarded as they return.
module fetch_unit
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [ILEN-1:0] id_inst
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [CW-1:0]   drop_q;
    logic [CW-1:0]   drop_d;
    logic [CW:0]     drop_sum_s;
    logic [XLEN-1:0] hold_pc_q;
    logic [ILEN-1:0] hold_inst_q;
    logic [CW-1:0]   count_s;
    logic [CW-1:0]   outst_s;
    fetch_entry_t    head_s;
    logic            req_valid_s;
    logic            hs_s;
    logic            fill_s;
    logic            pop_s;

    // count is registered, so a same-cycle pop cannot free a slot for a request.
    assign req_valid_s = ~reset & fetch_en & ~redirect_valid & (count_s < CW'(DEPTH));
    assign hs_s        = req_valid_s & imem_req_ready;
    assign pop_s       = head_s.filled & id_ready & ~redirect_valid;

    // Next PC and drop counter. A redirect outranks everything else.
    always_comb begin
        pc_d       = pc_q;
        drop_d     = drop_q;
        fill_s     = 1'b0;
        drop_sum_s = {1'b0, drop_q} + {1'b0, outst_s};
        if (redirect_valid) begin
            pc_d = redirect_pc;
            // Every outstanding request becomes a drop.
            // A response in this same cycle consumes one of those drops.
            if (imem_rsp_valid && (drop_sum_s != {(CW+1){1'b0}})) begin
                drop_d = drop_sum_s[CW-1:0] - CW'(1);
            end else begin
                drop_d = drop_sum_s[CW-1:0];
            end
        end else begin
            if (hs_s) begin
                pc_d = pc_q + INST_BYTES;
            end else begin
                pc_d = pc_q;
            end
            if (imem_rsp_valid) begin
                if (drop_q != {CW{1'b0}}) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    fill_s = 1'b1;
                end
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // PC and drop-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= RESET_VEC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    // Remember the last presented instruction so the decode outputs hold when empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_pc_q   <= '0;
            hold_inst_q <= '0;
        end else if (head_s.filled) begin
            hold_pc_q   <= head_s.pc;
            hold_inst_q <= head_s.inst;
        end else begin
            hold_pc_q   <= hold_pc_q;
            hold_inst_q <= hold_inst_q;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (redirect_valid),
        .alloc_i     (hs_s),
        .alloc_pc_i  (pc_q),
        .fill_i      (fill_s),
        .fill_inst_i (imem_rsp_data),
        .pop_i       (pop_s),
        .count_o     (count_s),
        .outst_o     (outst_s),
        .head_o      (head_s)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_q;
    assign id_valid       = head_s.filled;
    assign id_pc          = head_s.filled ? head_s.pc   : hold_pc_q;
    assign id_inst        = head_s.filled ? head_s.inst : hold_inst_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// - A request-level memory model answers in order with a chosen latency.
// - A scoreboard of expected queue contents is checked against the DUT at every negedge.
// - Directed scenarios add hand-computed literal expectations.
module tb_fetch_unit;
    import rv_pkg::*;

    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            fetch_en = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [31:0]     redirect_pc = 32'h0;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b0;
    logic [31:0]     imem_req_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [31:0]     imem_rsp_data = 32'h0;
    logic            id_valid;
    logic            id_ready = 1'b0;
    logic [31:0]     id_pc;
    logic [31:0]     id_inst;

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_inst        (id_inst)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Program image: each address holds a distinct word.
    function automatic logic [31:0] img(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Instruction memory model: in-order, one response per cycle.
    typedef struct { logic [31:0] addr; int due; int gen; } mreq_t;
    mreq_t pend[$];
    int    last_due = -1;
    int    lat_min = 1;
    int    lat_max = 1;
    int    rsp_gen = 0;
    bit    rr_rand = 1'b0;
    bit    ir_rand = 1'b0;

    // Scoreboard of what the queue must hold.
    typedef struct { logic [31:0] pc; bit filled; } ment_t;
    ment_t       mq[$];
    logic [31:0] mpc = RESET_VEC;
    int          cur_gen = 0;
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] pop_inst_log[$];

    function automatic logic [31:0] rl_at(input int i);
        return (i >= 0 && i < req_log.size()) ? req_log[i] : 32'hBAD0_BAD0;
    endfunction
    function automatic logic [31:0] pl_at(input int i);
        return (i >= 0 && i < pop_log.size()) ? pop_log[i] : 32'hBAD0_BAD0;
    endfunction
    function automatic logic [31:0] pil_at(input int i);
        return (i >= 0 && i < pop_inst_log.size()) ? pop_inst_log[i] : 32'hBAD0_BAD0;
    endfunction

    // Compare process: check outputs, then advance the model to the next edge.
    always @(negedge clk) begin : cmp
        bit exp_rv;
        bit exp_iv;
        bit found;
        int lat;
        int due;
        if (reset) begin
            check_eq("reset_req_valid", {31'h0, imem_req_valid}, 32'h0);
            check_eq("reset_id_valid", {31'h0, id_valid}, 32'h0);
            check_eq("reset_id_pc", id_pc, 32'h0);
            check_eq("reset_id_inst", id_inst, 32'h0);
            mq.delete();
            pend.delete();
            last_due = -1;
            mpc = RESET_VEC;
            cur_gen++;
        end else begin
            exp_rv = fetch_en && !redirect_valid && (mq.size() < DEPTH);
            check_eq("req_valid", {31'h0, imem_req_valid}, {31'h0, exp_rv});
            if (exp_rv && imem_req_valid) check_eq("req_addr", imem_req_addr, mpc);
            exp_iv = (mq.size() > 0) && mq[0].filled;
            check_eq("id_valid", {31'h0, id_valid}, {31'h0, exp_iv});
            if (exp_iv && id_valid) begin
                check_eq("id_pc", id_pc, mq[0].pc);
                check_eq("id_inst", id_inst, img(mq[0].pc));
            end
            if (redirect_valid) begin
                mq.delete();
                mpc = redirect_pc;
                cur_gen++;
            end else begin
                if (exp_iv && id_ready) begin
                    pop_log.push_back(id_pc);
                    pop_inst_log.push_back(id_inst);
                    void'(mq.pop_front());
                end
                if (imem_rsp_valid && rsp_gen == cur_gen) begin
                    found = 1'b0;
                    foreach (mq[i]) begin
                        if (!found && !mq[i].filled) begin
                            mq[i].filled = 1'b1;
                            found = 1'b1;
                        end
                    end
                    check_eq("rsp_has_outstanding", {31'h0, found}, 32'h1);
                end
                if (imem_req_valid && imem_req_ready) begin
                    req_log.push_back(imem_req_addr);
                    mq.push_back('{pc: mpc, filled: 1'b0});
                    mpc = mpc + 32'd4;
                    lat = $urandom_range(lat_max, lat_min);
                    due = ((cyc + lat) > (last_due + 1)) ? (cyc + lat) : (last_due + 1);
                    pend.push_back('{addr: imem_req_addr, due: due, gen: cur_gen});
                    last_due = due;
                end
            end
        end
    end

    // Advance one cycle; the memory model drives this cycle's response.
    task automatic step();
        @(posedge clk);
        #1;
        if (rr_rand) imem_req_ready = 1'($urandom_range(1, 0));
        if (ir_rand) id_ready = 1'($urandom_range(1, 0));
        if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = img(pend[0].addr);
            rsp_gen        = pend[0].gen;
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
        end
    endtask

    initial begin : stim
        int b;
        int p;
        int k;
        bit hit;
        repeat (3) step();
        reset = 1'b0;

        // 1: sequential fetch, latency 1, no stalls
        fetch_en = 1'b1; imem_req_ready = 1'b1; id_ready = 1'b1;
        repeat (5) step();
        b = pop_log.size();
        repeat (10) step();
        check_eq("t1_pops_in_10", pop_log.size() - b, 32'd10);
        check_eq("t1_req0", rl_at(0), 32'h0);
        check_eq("t1_req1", rl_at(1), 32'h4);
        check_eq("t1_pop0", pl_at(0), 32'h0);
        check_eq("t1_pop0_inst", pil_at(0), 32'h5A5A_0000);
        check_eq("t1_pop2", pl_at(2), 32'h8);

        // 2: decode stall fills the queue with exactly DEPTH requests
        fetch_en = 1'b0;
        repeat (8) step();
        b = req_log.size();
        p = pop_log.size();
        fetch_en = 1'b1; id_ready = 1'b0;
        repeat (10) step();
        check_eq("t2_reqs_issued", req_log.size() - b, 32'd4);
        check_eq("t2_req_valid_full", {31'h0, imem_req_valid}, 32'h0);
        fetch_en = 1'b0; id_ready = 1'b1;
        repeat (10) step();
        check_eq("t2_pops", pop_log.size() - p, 32'd4);
        for (int i = 0; i < 4; i++) check_eq("t2_order", pl_at(p + i), rl_at(b + i));

        // 3: two outstanding at latency 3, redirect drops both late responses
        lat_min = 3; lat_max = 3;
        repeat (4) step();
        fetch_en = 1'b1;
        step();
        step();
        fetch_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        p = pop_log.size();
        step();
        redirect_valid = 1'b0; fetch_en = 1'b1;
        repeat (12) step();
        check_eq("t3_first_pc", pl_at(p), 32'h0000_0100);
        check_eq("t3_first_inst", pil_at(p), 32'h5A5A_0100);

        // 4: redirect in the same cycle as a response with decode ready
        lat_min = 1; lat_max = 1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (imem_rsp_valid && id_valid) hit = 1'b1;
        end
        check_eq("t4_found_window", {31'h0, hit}, 32'h1);
        b = req_log.size();
        p = pop_log.size();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        repeat (6) step();
        check_eq("t4_next_req", rl_at(b), 32'h0000_0200);
        check_eq("t4_next_pop", pl_at(p), 32'h0000_0200);

        // 5: random req_ready, latency 1-5, random decode stalls, PC wraps
        rr_rand = 1'b1; ir_rand = 1'b1; lat_min = 1; lat_max = 5;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFE0;
        p = pop_log.size();
        step();
        redirect_valid = 1'b0;
        repeat (400) step();
        rr_rand = 1'b0; ir_rand = 1'b0; id_ready = 1'b1; fetch_en = 1'b0;
        repeat (20) step();
        check_eq("t5_first", pl_at(p), 32'hFFFF_FFE0);
        k = -1;
        for (int i = p; i < pop_log.size(); i++) if (k < 0 && pop_log[i] == 32'hFFFF_FFFC) k = i;
        check_eq("t5_wrap_seen", {31'h0, (k >= 0)}, 32'h1);
        check_eq("t5_wrap_next", pl_at(k + 1), 32'h0);

        // 6: asynchronous reset with the queue full
        fetch_en = 1'b1; imem_req_ready = 1'b1; lat_min = 1; lat_max = 1; id_ready = 1'b0;
        repeat (10) step();
        check_eq("t6_full_valid", {31'h0, id_valid}, 32'h1);
        #2;
        reset = 1'b1; imem_rsp_valid = 1'b0;
        #1;
        check_eq("t6_async_id_valid", {31'h0, id_valid}, 32'h0);
        check_eq("t6_async_req_valid", {31'h0, imem_req_valid}, 32'h0);
        step();
        step();
        reset = 1'b0; id_ready = 1'b1;
        b = req_log.size();
        repeat (5) step();
        check_eq("t6_restart_addr", rl_at(b), RESET_VEC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
